// File: rtl/perf_threshold_irq_pkg.sv
// Purpose : Shared constants and types for the HPM threshold interrupt block.
//           Holds the data-path width, the two custom M-mode CSR addresses
//           and the interrupt FSM state encoding.
// Contents: XLEN, CSR_MHPM_OVF_EN, CSR_MHPM_OVF_PEND, hpm_irq_state_e.
package perf_threshold_irq_pkg;

    localparam int XLEN = 64;

    localparam logic [11:0] CSR_MHPM_OVF_EN   = 12'h7C0;
    localparam logic [11:0] CSR_MHPM_OVF_PEND = 12'h7C1;

    typedef enum logic [1:0] {
        IRQ_IDLE     = 2'd0,
        IRQ_ASSERT   = 2'd1,
        IRQ_WAIT_CLR = 2'd2
    } hpm_irq_state_e;

endpackage

// File: rtl/perf_threshold_irq.sv
// Purpose : Converts HPM counter threshold flags into sticky pending bits,
//           masks them with a CSR enable register and drives one level
//           interrupt towards the trap logic. A holdoff counter enforces a
//           minimum idle gap after each interrupt deassertion.
// Ports   : clk_i, rst_ni        clock, async active-low reset
//           debug_mode_i         core in debug mode (drops rises, masks irq)
//           threshold_i          per-counter level flags (bit i = counter i+3)
//           addr_i/we_i/data_i   CSR write port (valid every cycle)
//           data_o               CSR read data, combinational from addr_i
//           irq_o                registered level interrupt request
//           irq_ack_i            trap-taken pulse for this interrupt
//           cause_o              index of the counter behind the interrupt
module perf_threshold_irq
    import perf_threshold_irq_pkg::*;
#(
    parameter int NumCounters   = 6,
    parameter int HoldoffCycles = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   debug_mode_i,
    input  logic [NumCounters-1:0] threshold_i,
    input  logic [11:0]            addr_i,
    input  logic                   we_i,
    input  logic [XLEN-1:0]        data_i,
    output logic [XLEN-1:0]        data_o,
    output logic                   irq_o,
    input  logic                   irq_ack_i,
    output logic [2:0]             cause_o
);

    // Holdoff counter needs at least one bit even when holdoff is disabled.
    localparam int HW = (HoldoffCycles > 0) ? $clog2(HoldoffCycles + 1) : 1;
    localparam logic [HW-1:0] HOLDOFF_LOAD = HW'(HoldoffCycles);

    logic [NumCounters-1:0] r_thr;
    logic [NumCounters-1:0] r_pend;
    logic [NumCounters-1:0] r_en;
    logic [2:0]             r_cause;
    logic [HW-1:0]          r_holdoff;
    logic                   r_irq;
    hpm_irq_state_e         r_state;

    logic [NumCounters-1:0] w_set;
    logic [NumCounters-1:0] w_clr;
    logic [NumCounters-1:0] w_masked;
    logic                   w_act;
    logic [2:0]             w_pick;
    logic                   w_found;
    hpm_irq_state_e         w_state_d;
    logic [2:0]             w_cause_d;
    logic [HW-1:0]          w_holdoff_d;

    // Rising-edge detect; rises seen in debug mode are discarded, not deferred.
    always_comb begin
        if (debug_mode_i) begin
            w_set = '0;
        end else begin
            w_set = threshold_i & ~r_thr;
        end
    end

    // W1C mask for the pending register.
    always_comb begin
        if (we_i && (addr_i == CSR_MHPM_OVF_PEND)) begin
            w_clr = data_i[NumCounters-1:0];
        end else begin
            w_clr = '0;
        end
    end

    assign w_masked = r_pend & r_en;
    assign w_act    = |w_masked;

    // Lowest-index enabled pending counter.
    always_comb begin
        w_pick  = 3'd0;
        w_found = 1'b0;
        for (int i = 0; i < NumCounters; i++) begin
            if (w_masked[i] && !w_found) begin
                w_pick  = 3'(i);
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    // CSR read mux.
    always_comb begin
        case (addr_i)
            CSR_MHPM_OVF_EN:   data_o = {{(XLEN-NumCounters){1'b0}}, r_en};
            CSR_MHPM_OVF_PEND: data_o = {{(XLEN-NumCounters){1'b0}}, r_pend};
            default:           data_o = {XLEN{1'b0}};
        endcase
    end

    // Interrupt FSM next-state, cause latch and holdoff countdown.
    always_comb begin
        w_state_d   = r_state;
        w_cause_d   = r_cause;
        w_holdoff_d = r_holdoff;
        case (r_state)
            IRQ_IDLE: begin
                if (r_holdoff != '0) begin
                    w_holdoff_d = r_holdoff - HW'(1);
                end else begin
                    w_holdoff_d = r_holdoff;
                end
                if (w_act && (r_holdoff == '0) && !debug_mode_i) begin
                    w_state_d = IRQ_ASSERT;
                    w_cause_d = w_pick;
                end else begin
                    w_state_d = IRQ_IDLE;
                end
            end
            IRQ_ASSERT: begin
                // Debug freezes the handshake; it resumes on debug exit.
                if (debug_mode_i) begin
                    w_state_d = IRQ_ASSERT;
                end else if (irq_ack_i) begin
                    w_state_d = IRQ_WAIT_CLR;
                end else if (!w_act) begin
                    w_state_d   = IRQ_IDLE;
                    w_holdoff_d = HOLDOFF_LOAD;
                end else begin
                    w_state_d = IRQ_ASSERT;
                end
            end
            IRQ_WAIT_CLR: begin
                if (!w_act) begin
                    w_state_d   = IRQ_IDLE;
                    w_holdoff_d = HOLDOFF_LOAD;
                end else begin
                    w_state_d = IRQ_WAIT_CLR;
                end
            end
            default: begin
                w_state_d   = IRQ_IDLE;
                w_holdoff_d = '0;
            end
        endcase
    end

    // State, CSR and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_thr     <= '0;
            r_pend    <= '0;
            r_en      <= '0;
            r_cause   <= 3'd0;
            r_holdoff <= '0;
            r_irq     <= 1'b0;
            r_state   <= IRQ_IDLE;
        end else begin
            r_thr     <= threshold_i;
            // Set after clear so a same-cycle rise beats the W1C.
            r_pend    <= (r_pend & ~w_clr) | w_set;
            if (we_i && (addr_i == CSR_MHPM_OVF_EN)) begin
                r_en <= data_i[NumCounters-1:0];
            end else begin
                r_en <= r_en;
            end
            r_cause   <= w_cause_d;
            r_holdoff <= w_holdoff_d;
            r_irq     <= (w_state_d == IRQ_ASSERT) && !debug_mode_i;
            r_state   <= w_state_d;
        end
    end

    assign irq_o   = r_irq;
    assign cause_o = r_cause;

endmodule
